generic_bus_arbiter: RTL
========================

GENERIC_BUS_ARBITER -- requirements
Module: generic_bus_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-002 Parameter TIMEOUT, default 256: maximum XFER cycles before forced termination (>=2).
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 nRST  input  1  reset, synchronous, active-low.
REQ-005 req_addr  input  NUM_REQ*32  per-requester address; requester i occupies bits [32i+31:32i].
REQ-006 req_wdata  input  NUM_REQ*32  per-requester write data, same packing.
REQ-007 req_byte_en  input  NUM_REQ*4  per-requester byte enables.
REQ-008 req_ren / req_wen  input  NUM_REQ each  per-requester read/write request, held until that requester's busy is low.
REQ-009 req_busy  output  NUM_REQ  per-requester busy; low for exactly one cycle at completion.
REQ-010 req_rdata  output  32  read data broadcast to all requesters.
REQ-011 req_err  output  1  completion was a timeout.
REQ-012 out_addr / out_wdata  output  32 each  downstream bus address and write data.
REQ-013 out_byte_en  output  4;  out_ren / out_wen  output  1 each  downstream request.
REQ-014 out_rdata  input  32;  out_busy  input  1  downstream response; low = transfer complete.
REQ-015 grant_valid  output  1;  grant_id  output  $clog2(NUM_REQ)  current owner, for debug/perf counters.

Function
REQ-016 FSM states: IDLE and XFER only.
REQ-017 IDLE: if any requester has ren|wen, select a winner, latch its addr/wdata/byte_en/ren/wen into internal registers, record grant_id, go to XFER next cycle; otherwise stay in IDLE.
REQ-018 Winner selection: round-robin; search from index ptr upward with wrap to 0; the first active requester wins.
REQ-019 ptr: 0 at reset; on every XFER completion (normal or timeout) ptr <= (grant_id+1) mod NUM_REQ.
REQ-020 Latch rule: if the winner asserts ren and wen together, latch wen=1, ren=0 (write wins).
REQ-021 XFER: drive out_* from the latched registers; later changes on the winner's req_* inputs are ignored until completion.
REQ-022 IDLE outputs: out_ren=out_wen=0, out_addr=out_wdata=0, out_byte_en=0, grant_valid=0, req_busy all 1.
REQ-023 XFER: grant_valid=1; req_busy[grant_id]=out_busy (combinational); all other req_busy bits=1.
REQ-024 Normal completion: first XFER cycle with out_busy=0; req_rdata=out_rdata that cycle; next state IDLE.
REQ-025 req_rdata equals out_rdata combinationally in every cycle except a timeout cycle.
REQ-026 Latency: request first seen in IDLE cycle t -> out_ren/out_wen high at t+1; zero-wait downstream completes at t+1; IDLE at t+2, giving a minimum one-cycle bubble between transfers.
REQ-027 Timeout counter: cleared on IDLE->XFER, incremented each XFER cycle with out_busy=1.
REQ-028 Timeout: when the counter reaches TIMEOUT-1 with out_busy still 1, force completion that cycle: req_busy[grant_id]=0, req_err=1, req_rdata=0; next state IDLE.
REQ-029 Timeout leaves downstream request deasserted from the next cycle; a late downstream response is ignored.
REQ-030 req_err=0 in all cycles other than a timeout cycle.
REQ-031 Requests arriving during XFER wait; they are arbitrated in the next IDLE cycle.

Reset
REQ-032 nRST low at a rising edge -> next cycle: state IDLE, ptr=0, grant_id=0, counter=0, latched registers=0, all outputs at REQ-022 values, req_err=0; this applies in every state, including mid-XFER.
REQ-033 No transfer is completed or reported as a timeout as a result of reset.

Verification
REQ-034 req_ren[0]=1, req_addr[0]=0x0000_0100, out_busy high for 2 cycles then low with out_rdata=0xDEAD_BEEF -> out_ren=1 and out_addr=0x100 from t+1; req_busy[0]=0 and req_rdata=0xDEAD_BEEF in the completion cycle only.
REQ-035 After reset, all 4 requesters assert ren continuously, zero-wait downstream -> grant_id sequence 0,1,2,3,0 with an IDLE cycle between each grant.
REQ-036 Requesters 0 and 2 request continuously -> grants alternate 0,2,0,2; requesters 1 and 3 are never granted.
REQ-037 TIMEOUT=8, out_busy stuck at 1 -> XFER lasts exactly 8 cycles; last cycle shows req_err=1, req_busy[g]=0, req_rdata=0; IDLE follows; ptr advances.
REQ-038 nRST low during the 3rd XFER cycle of a write from requester 1 -> next cycle shows IDLE values; next grant with all requesting is 0.
REQ-039 Requester 3 asserts ren=wen=1, wdata=0x1234_5678 -> out_wen=1, out_ren=0, out_wdata=0x1234_5678; changing req_addr[3] mid-XFER leaves out_addr unchanged.

Source files
------------

// File: rtl/generic_bus_arbiter.sv
// Round-robin arbiter that multiplexes NUM_REQ requesters onto one downstream bus,
// one transfer at a time, with a per-transfer timeout that forces completion.
module generic_bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [NUM_REQ*32-1:0]        req_addr,
  input  logic [NUM_REQ*32-1:0]        req_wdata,
  input  logic [NUM_REQ*4-1:0]         req_byte_en,
  input  logic [NUM_REQ-1:0]           req_ren,
  input  logic [NUM_REQ-1:0]           req_wen,
  output logic [NUM_REQ-1:0]           req_busy,
  output logic [31:0]                  req_rdata,
  output logic                         req_err,
  output logic [31:0]                  out_addr,
  output logic [31:0]                  out_wdata,
  output logic [3:0]                   out_byte_en,
  output logic                         out_ren,
  output logic                         out_wen,
  input  logic [31:0]                  out_rdata,
  input  logic                         out_busy,
  output logic                         grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_grant_id;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [3:0]      r_byte_en;
  logic            r_ren;
  logic            r_wen;

  logic [NUM_REQ-1:0] w_active;
  logic [IW:0]        w_pick;
  logic               w_found;
  logic [IW-1:0]      w_win;
  logic [31:0]        w_sel_addr;
  logic [31:0]        w_sel_wdata;
  logic [3:0]         w_sel_byte_en;
  logic               w_sel_ren;
  logic               w_sel_wen;
  logic               w_xfer;
  logic               w_timeout;
  logic               w_done;
  logic [IW-1:0]      w_ptr_nxt;

  // Returns {found, index} of the first active requester at or above ptr, wrapping to 0.
  function automatic logic [IW:0] f_rr_pick(input logic [NUM_REQ-1:0] act,
                                            input logic [IW-1:0] ptr);
    logic [IW:0]   idx;
    logic          found;
    logic [IW-1:0] win;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + (IW+1)'(k);
      if (idx >= (IW+1)'(NUM_REQ)) begin
        idx = idx - (IW+1)'(NUM_REQ);
      end else begin
        idx = idx;
      end
      if (!found && act[idx[IW-1:0]]) begin
        found = 1'b1;
        win   = idx[IW-1:0];
      end else begin
        found = found;
      end
    end
    return {found, win};
  endfunction

  assign w_active      = req_ren | req_wen;
  assign w_pick        = f_rr_pick(w_active, r_ptr);
  assign w_found       = w_pick[IW];
  assign w_win         = w_pick[IW-1:0];
  assign w_sel_addr    = req_addr[32*int'(w_win) +: 32];
  assign w_sel_wdata   = req_wdata[32*int'(w_win) +: 32];
  assign w_sel_byte_en = req_byte_en[4*int'(w_win) +: 4];
  assign w_sel_ren     = req_ren[w_win];
  assign w_sel_wen     = req_wen[w_win];

  // Completion is suppressed while reset is asserted so reset never reports a finished transfer.
  assign w_xfer    = (r_state == ST_XFER);
  assign w_timeout = w_xfer && nRST && out_busy && (r_cnt == CW'(TIMEOUT - 1));
  assign w_done    = w_xfer && nRST && (!out_busy || w_timeout);
  assign w_ptr_nxt = (r_grant_id == IW'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;

  // Next-state selection.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_found) w_state_nxt = ST_XFER;
        else         w_state_nxt = ST_IDLE;
      end
      ST_XFER: begin
        if (w_done) w_state_nxt = ST_IDLE;
        else        w_state_nxt = ST_XFER;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, grant capture, timeout counter and round-robin pointer.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_cnt      <= '0;
      r_addr     <= 32'h0000_0000;
      r_wdata    <= 32'h0000_0000;
      r_byte_en  <= 4'h0;
      r_ren      <= 1'b0;
      r_wen      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_found) begin
        r_grant_id <= w_win;
        r_addr     <= w_sel_addr;
        r_wdata    <= w_sel_wdata;
        r_byte_en  <= w_sel_byte_en;
        // Write wins when a requester raises both strobes.
        r_wen      <= w_sel_wen;
        r_ren      <= w_sel_ren & ~w_sel_wen;
        r_cnt      <= '0;
      end else if (w_xfer && out_busy) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= r_cnt;
      end
      if (w_done) r_ptr <= w_ptr_nxt;
      else        r_ptr <= r_ptr;
    end
  end

  // Downstream drive and requester-side responses.
  always_comb begin
    out_addr    = 32'h0000_0000;
    out_wdata   = 32'h0000_0000;
    out_byte_en = 4'h0;
    out_ren     = 1'b0;
    out_wen     = 1'b0;
    grant_valid = 1'b0;
    req_busy    = '1;
    case (r_state)
      ST_XFER: begin
        out_addr    = r_addr;
        out_wdata   = r_wdata;
        out_byte_en = r_byte_en;
        out_ren     = r_ren;
        out_wen     = r_wen;
        grant_valid = 1'b1;
        if (w_done) req_busy[r_grant_id] = 1'b0;
        else        req_busy[r_grant_id] = 1'b1;
      end
      default: begin
        grant_valid = 1'b0;
      end
    endcase
    req_rdata = w_timeout ? 32'h0000_0000 : out_rdata;
    req_err   = w_timeout;
    grant_id  = r_grant_id;
  end

endmodule
